// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus among the ALU (src 0), LSB (src 1)
// and branch unit (src 2). Each producer fills a private FIFO; a round-robin
// scheduler pops one head per cycle onto the registered broadcast bus.
module cdb_arbiter #(
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,

    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_data,

    input  logic              lsb_valid,
    output logic              lsb_ready,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_data,

    input  logic              br_valid,
    output logic              br_ready,
    input  logic [TAG_W-1:0]  br_tag,
    input  logic [DATA_W-1:0] br_data,
    input  logic              br_jump_judge,
    input  logic [ADDR_W-1:0] br_pc,

    output logic              cdb_valid,
    output logic [1:0]        cdb_src,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    output logic              cdb_jump_judge,
    output logic [ADDR_W-1:0] cdb_pc
);

    localparam int unsigned NSRC  = 3;
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              jump_judge;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t           mem   [NSRC][QDEPTH];
    logic [PTR_W-1:0] head  [NSRC];
    logic [PTR_W-1:0] tail  [NSRC];
    logic [CNT_W-1:0] count [NSRC];
    logic [1:0]       last_grant;

    entry_t          in_entry [NSRC];
    entry_t          win;
    logic [NSRC-1:0] valid_in;
    logic [NSRC-1:0] ready;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] pop;
    logic            gnt_vld;
    logic [1:0]      gnt_id;
    logic [1:0]      start;
    logic [1:0]      cand;
    logic [2:0]      sum;

    // Normalise producer payloads; non-branch entries carry zero side fields
    always_comb begin
        in_entry[0].tag        = alu_tag;
        in_entry[0].data       = alu_data;
        in_entry[0].jump_judge = 1'b0;
        in_entry[0].pc         = '0;
        in_entry[1].tag        = lsb_tag;
        in_entry[1].data       = lsb_data;
        in_entry[1].jump_judge = 1'b0;
        in_entry[1].pc         = '0;
        in_entry[2].tag        = br_tag;
        in_entry[2].data       = br_data;
        in_entry[2].jump_judge = br_jump_judge;
        in_entry[2].pc         = br_pc;
        valid_in               = {br_valid, lsb_valid, alu_valid};
    end

    // Ready comes only from registered occupancy; a flush drops same-cycle offers
    always_comb begin
        ready = '0;
        req   = '0;
        push  = '0;
        for (int i = 0; i < NSRC; i++) begin
            ready[i] = rdy & (count[i] != CNT_W'(QDEPTH));
            req[i]   = (count[i] != '0);
            push[i]  = valid_in[i] & ready[i] & ~clear & ~rst;
        end
    end

    assign alu_ready = ready[0];
    assign lsb_ready = ready[1];
    assign br_ready  = ready[2];

    // Round-robin pick starting just after the last winner, wrapping 2->0
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = last_grant;
        start   = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < NSRC; k++) begin
            sum = 3'(start) + 3'(k);
            if (sum >= 3'd3) begin
                sum = sum - 3'd3;
            end
            cand = sum[1:0];
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_id  = cand;
            end
        end
    end

    // Head entry of the winning FIFO and the matching pop strobe
    always_comb begin
        win = '0;
        pop = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (gnt_vld && (gnt_id == 2'(i))) begin
                win    = mem[i][head[i]];
                pop[i] = 1'b1;
            end
        end
    end

    // FIFO storage writes at the tail pointer
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (push[i]) begin
                mem[i][tail[i]] <= in_entry[i];
            end
        end
    end

    // Pointers, occupancy, grant history and the broadcast registers
    always_ff @(posedge clk) begin
        if (rst || (rdy && clear)) begin
            for (int i = 0; i < NSRC; i++) begin
                head[i]  <= '0;
                tail[i]  <= '0;
                count[i] <= '0;
            end
            last_grant     <= 2'd2;
            cdb_valid      <= 1'b0;
            cdb_src        <= '0;
            cdb_tag        <= '0;
            cdb_data       <= '0;
            cdb_jump_judge <= 1'b0;
            cdb_pc         <= '0;
        end else if (rdy) begin
            for (int i = 0; i < NSRC; i++) begin
                if (push[i]) begin
                    tail[i] <= tail[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    head[i] <= head[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
            if (gnt_vld) begin
                last_grant     <= gnt_id;
                cdb_valid      <= 1'b1;
                cdb_src        <= gnt_id;
                cdb_tag        <= win.tag;
                cdb_data       <= win.data;
                cdb_jump_judge <= win.jump_judge;
                cdb_pc         <= win.pc;
            end else begin
                cdb_valid      <= 1'b0;
                cdb_jump_judge <= 1'b0;
                cdb_pc         <= '0;
            end
        end
    end

endmodule
